// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use stall control.
// Shadows rd/regwrite/memread of the instructions in EX, MEM and WB beside the ID/EX register.
module fwd_hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             branch_flush,
    output logic             stall,
    output logic [1:0]       Forward_A,
    output logic [1:0]       Forward_B,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]      opcode;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic            rs1_used, rs2_used;

    logic            ex_valid_q, ex_valid_d;
    logic [RA_W-1:0] ex_rd_q, ex_rd_d;
    logic            ex_rw_q, ex_rw_d;
    logic            ex_mr_q, ex_mr_d;
    logic            mem_valid_q, mem_rw_q;
    logic [RA_W-1:0] mem_rd_q;
    logic            wb_valid_q, wb_rw_q;
    logic [RA_W-1:0] wb_rd_q;
    logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, load_ex;

    assign opcode   = id_instr[6:0];
    assign rs1      = id_instr[15 +: RA_W];
    assign rs2      = id_instr[20 +: RA_W];
    assign rd       = id_instr[7 +: RA_W];
    assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign rs2_used = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    function automatic logic match(input logic used, input logic [RA_W-1:0] src,
                                   input logic v, input logic rw, input logic [RA_W-1:0] prd);
        return used && v && rw && (prd != '0) && (prd == src);
    endfunction

    assign ex_hit1  = match(rs1_used, rs1, ex_valid_q, ex_rw_q, ex_rd_q);
    assign ex_hit2  = match(rs2_used, rs2, ex_valid_q, ex_rw_q, ex_rd_q);
    assign mem_hit1 = match(rs1_used, rs1, mem_valid_q, mem_rw_q, mem_rd_q);
    assign mem_hit2 = match(rs2_used, rs2, mem_valid_q, mem_rw_q, mem_rd_q);

    // A flush squashes the ID instruction, so it never stalls and never counts.
    assign stall   = id_valid && !branch_flush && ex_valid_q && ex_mr_q && (ex_hit1 || ex_hit2);
    assign load_ex = id_valid && !branch_flush && !stall;

    always_comb begin
        ex_valid_d = 1'b0;
        ex_rd_d    = '0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        fwd_a_d    = 2'b00;
        fwd_b_d    = 2'b00;
        cnt_d      = cnt_q;
        if (load_ex) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = rd;
            ex_rw_d    = id_reg_write;
            ex_mr_d    = id_mem_read;
            // The EX producer is younger than the MEM one, so it takes priority.
            fwd_a_d    = ex_hit1 ? 2'b10 : (mem_hit1 ? 2'b01 : 2'b00);
            fwd_b_d    = ex_hit2 ? 2'b10 : (mem_hit2 ? 2'b01 : 2'b00);
        end
        if (stall && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            cnt_q       <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_valid_q <= ex_valid_q;
            mem_rd_q    <= ex_rd_q;
            mem_rw_q    <= ex_rw_q;
            wb_valid_q  <= mem_valid_q;
            wb_rd_q     <= mem_rd_q;
            wb_rw_q     <= mem_rw_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            cnt_q       <= cnt_d;
        end
    end

    // WB is shadowed for completeness; the write-first register file covers distance 3.
    logic unused_bits;
    assign unused_bits = ^{wb_valid_q, wb_rd_q, wb_rw_q, id_instr[31:25], id_instr[14:12]};

    assign Forward_A   = fwd_a_q;
    assign Forward_B   = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vector table, hand sequences for reset and
// counter saturation, and a randomized run against a distance-based reference model.
module tb_fwd_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   id_instr = 32'd0;
    logic          id_valid = 1'b0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          branch_flush = 1'b0;
    logic          stall;
    logic [1:0]    Forward_A, Forward_B;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.RA_W(5), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .branch_flush(branch_flush),
        .stall       (stall),
        .Forward_A   (Forward_A),
        .Forward_B   (Forward_B),
        .stall_count (stall_count)
    );

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] f_add(int rd, int rs1, int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] f_sub(int rd, int rs1, int rs2);
        return {7'b0100000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] f_addi(int rd, int rs1, int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] f_lw(int rd, int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] f_sw(int rs2, int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] f_beq(int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'b1100011};
    endfunction
    function automatic logic [31:0] f_lui(int rd, int imm20);
        return {20'(imm20), 5'(rd), 7'b0110111};
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One pipeline cycle: drive ID, sample combinational stall, then registered outputs after the edge.
    task automatic cycle(input logic [31:0] ins, input logic v, input logic rw, input logic mr,
                         input logic fl, output logic st, output logic [1:0] fa,
                         output logic [1:0] fb, output logic [CW-1:0] cnt);
        id_instr = ins; id_valid = v; id_reg_write = rw; id_mem_read = mr; branch_flush = fl;
        #2;
        st = stall;
        @(posedge clk);
        #1;
        fa = Forward_A; fb = Forward_B; cnt = stall_count;
    endtask

    // ---------------- reference model ----------------
    // hist[0] is the instruction one ahead of ID, hist[1] two ahead; a bubble has v=0.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } slot_t;

    slot_t hist [2];
    int    m_cnt;

    task automatic model_clear();
        hist[0] = '0; hist[1] = '0; m_cnt = 0;
    endtask

    function automatic void uses(input logic [31:0] ins, output logic u1, output logic u2);
        logic [6:0] op;
        op = ins[6:0];
        u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    // Distance to the nearest in-flight writer of r: 1 -> 10, 2 -> 01, none -> 00.
    function automatic logic [1:0] m_fwd(input logic used, input logic [4:0] r);
        for (int d = 0; d < 2; d++) begin
            if (used && hist[d].v && hist[d].rw && hist[d].rd != 5'd0 && hist[d].rd == r)
                return (d == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic model_cycle(input logic [31:0] ins, input logic v, input logic rw,
                               input logic mr, input logic fl, input string tag,
                               output logic est);
        logic u1, u2, issue, st;
        logic [1:0] efa, efb, fa, fb;
        logic [CW-1:0] cnt;
        uses(ins, u1, u2);
        est   = v && !fl && hist[0].v && hist[0].mr &&
                (m_fwd(u1, ins[19:15]) == 2'b10 || m_fwd(u2, ins[24:20]) == 2'b10);
        issue = v && !fl && !est;
        efa   = issue ? m_fwd(u1, ins[19:15]) : 2'b00;
        efb   = issue ? m_fwd(u2, ins[24:20]) : 2'b00;
        if (est && m_cnt < (1 << CW) - 1) m_cnt++;
        cycle(ins, v, rw, mr, fl, st, fa, fb, cnt);
        chk({tag, "_stall"}, 32'(st), 32'(est));
        chk({tag, "_fa"}, 32'(fa), 32'(efa));
        chk({tag, "_fb"}, 32'(fb), 32'(efb));
        chk({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
        hist[1] = hist[0];
        hist[0] = issue ? {1'b1, ins[11:7], rw, mr} : '0;
    endtask

    task automatic do_reset();
        id_valid = 1'b0; branch_flush = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        model_clear();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] ins;
        logic        v, rw, mr, fl, st;
        logic [1:0]  fa, fb;
        int          cnt;
    } vec_t;

    vec_t tv[$];

    task automatic add_vec(input logic [31:0] ins, input logic v, input logic rw, input logic mr,
                           input logic fl, input logic st, input logic [1:0] fa,
                           input logic [1:0] fb, input int cnt);
        vec_t t;
        t.ins = ins; t.v = v; t.rw = rw; t.mr = mr; t.fl = fl;
        t.st = st; t.fa = fa; t.fb = fb; t.cnt = cnt;
        tv.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        logic [1:0] fa, fb;
        logic [CW-1:0] cnt;
        logic est;

        //      instr               v     rw    mr    fl    stall fa     fb     cnt
        add_vec(f_add(1, 2, 3),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        add_vec(f_add(4, 1, 5),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 0);
        add_vec(NOP,                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        add_vec(f_add(1, 2, 3),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        add_vec(NOP,                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        add_vec(f_sub(6, 7, 1),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 0);
        add_vec(NOP,                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        add_vec(f_lw(1, 2),         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        add_vec(f_add(3, 1, 1),     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1);
        add_vec(f_add(3, 1, 1),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1);
        add_vec(NOP,                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_addi(1, 2, 0),    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_addi(1, 0, 5),    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_add(2, 1, 1),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1);
        add_vec(f_addi(0, 6, 1),    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_addi(0, 6, 1),    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_add(7, 0, 0),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_lw(1, 2),         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_add(3, 1, 0),     1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_add(3, 1, 0),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1);
        add_vec(f_add(9, 1, 1),     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_add(10, 3, 3),    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1);
        add_vec(f_lui(4, 'h50),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_addi(11, 0, 4),   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_sw(11, 0),        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1);
        add_vec(NOP,                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        // load-use on rs2 only, store/branch rs2 forwarding, then setup for the reset test
        add_vec(f_lw(1, 2),         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        add_vec(f_sub(2, 3, 1),     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2);
        add_vec(f_sub(2, 3, 1),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2);
        add_vec(f_beq(5, 2),        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2);
        add_vec(f_lw(1, 2),         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2);
        add_vec(f_add(2, 1, 1),     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3);
        add_vec(f_add(2, 1, 1),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 3);
        add_vec(f_add(1, 2, 3),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 3);
        add_vec(f_add(4, 1, 5),     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 3);

        do_reset();
        chk("reset_fa", 32'(Forward_A), 32'd0);
        chk("reset_fb", 32'(Forward_B), 32'd0);
        chk("reset_cnt", 32'(stall_count), 32'd0);

        for (int i = 0; i < tv.size(); i++) begin
            cycle(tv[i].ins, tv[i].v, tv[i].rw, tv[i].mr, tv[i].fl, st, fa, fb, cnt);
            chk($sformatf("vec%0d_stall", i), 32'(st), 32'(tv[i].st));
            chk($sformatf("vec%0d_fa", i), 32'(fa), 32'(tv[i].fa));
            chk($sformatf("vec%0d_fb", i), 32'(fb), 32'(tv[i].fb));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tv[i].cnt));
        end

        // Asynchronous reset while Forward_A=10 and the counter is non-zero.
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_fa", 32'(Forward_A), 32'd0);
        chk("midrst_fb", 32'(Forward_B), 32'd0);
        chk("midrst_cnt", 32'(stall_count), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        #2;
        reset = 1'b0;
        // Pre-reset producers of x4/x1 must be forgotten.
        cycle(f_add(6, 4, 1), 1'b1, 1'b1, 1'b0, 1'b0, st, fa, fb, cnt);
        chk("postrst_add_stall", 32'(st), 32'd0);
        chk("postrst_add_fa", 32'(fa), 32'd0);
        chk("postrst_add_fb", 32'(fb), 32'd0);
        cycle(f_lui(5, 'h12345), 1'b1, 1'b1, 1'b0, 1'b0, st, fa, fb, cnt);
        chk("postrst_lui_fa", 32'(fa), 32'd0);
        chk("postrst_lui_fb", 32'(fb), 32'd0);

        // Counter saturation: 20 load-use stalls into a 4-bit counter.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            model_cycle(f_lw(1, 2), 1'b1, 1'b1, 1'b1, 1'b0, "sat_lw", est);
            model_cycle(f_add(3, 1, 1), 1'b1, 1'b1, 1'b0, 1'b0, "sat_use", est);
            model_cycle(f_add(3, 1, 1), 1'b1, 1'b1, 1'b0, 1'b0, "sat_use2", est);
        end
        chk("sat_final_cnt", 32'(stall_count), 32'd15);

        // Randomized traffic on a small register pool so hazards are frequent.
        begin
            logic [31:0] ins;
            logic v, rw, mr, fl, last_st;
            ins = NOP; v = 1'b1; rw = 1'b1; mr = 1'b0; last_st = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (!last_st) begin
                    int k, a, b, c;
                    k = $urandom_range(0, 6);
                    a = $urandom_range(0, 3);
                    b = $urandom_range(0, 3);
                    c = $urandom_range(0, 3);
                    rw = 1'b1; mr = 1'b0;
                    case (k)
                        0: ins = f_add(a, b, c);
                        1: ins = f_sub(a, b, c);
                        2: ins = f_addi(a, b, $urandom_range(0, 31));
                        3: begin ins = f_lw(a, b); mr = 1'b1; end
                        4: begin ins = f_sw(b, c); rw = 1'b0; end
                        5: begin ins = f_beq(b, c); rw = 1'b0; end
                        default: ins = f_lui(a, $urandom_range(0, 1023));
                    endcase
                    v = ($urandom_range(0, 9) != 0);
                end
                fl = ($urandom_range(0, 9) == 0);
                model_cycle(ins, v, rw, mr, fl, "rand", last_st);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
